jedro_1_mem_arbiter: RTL

- Parametrised N-channel arbiter that merges the core's request/response memory channels onto one shared memory port.
- Every channel uses the core's existing req/rsp valid/ready signal set.
- Used by the next core top to run instruction fetch, LSU and later debug/DMA masters over a single bus.
- Tracks outstanding requests in an ID FIFO and routes in-order responses back to the issuing channel.

---
 rtl/jedro_1_mem_arbiter.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/jedro_1_mem_arbiter.sv
// N-channel memory arbiter: merges req/rsp channels onto one memory port.
// Optional JEDRO_1_ARB_ROUND_ROBIN_EN selects round-robin over fixed priority.
package jedro_1_defines;
  localparam int XLEN   = 32;
  localparam int NBYTES = 4;
endpackage

module jedro_1_mem_arbiter
  import jedro_1_defines::*;
#(
  parameter int NCH             = 2,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                               clk_i,
  input  logic                               rstn_i,
  input  logic [NCH*XLEN-1:0]                ch_req_addr_i,
  input  logic [NCH*XLEN-1:0]                ch_req_data_i,
  input  logic [NCH*NBYTES-1:0]              ch_req_strobe_i,
  input  logic [NCH-1:0]                     ch_req_write_i,
  input  logic [NCH-1:0]                     ch_req_valid_i,
  output logic [NCH-1:0]                     ch_req_ready_o,
  output logic [NCH*XLEN-1:0]                ch_rsp_data_o,
  output logic [NCH-1:0]                     ch_rsp_error_o,
  output logic [NCH-1:0]                     ch_rsp_valid_o,
  input  logic [NCH-1:0]                     ch_rsp_ready_i,
  output logic [XLEN-1:0]                    mem_req_addr_o,
  output logic [XLEN-1:0]                    mem_req_data_o,
  output logic [NBYTES-1:0]                  mem_req_strobe_o,
  output logic                               mem_req_write_o,
  output logic                               mem_req_valid_o,
  input  logic                               mem_req_ready_i,
  input  logic [XLEN-1:0]                    mem_rsp_data_i,
  input  logic                               mem_rsp_error_i,
  input  logic                               mem_rsp_valid_i,
  output logic                               mem_rsp_ready_o,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_o
);

  localparam int IDW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int AW  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int PW  = $clog2(MAX_OUTSTANDING) + 1;
  localparam int OW  = $clog2(MAX_OUTSTANDING + 1);

  logic           active_q, active_d;
  logic           lock_q, lock_d;
  logic [IDW-1:0] lock_id_q, lock_id_d;
  logic [PW-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
  logic [IDW-1:0] fifo_q [MAX_OUTSTANDING];
  logic [IDW-1:0] fifo_d [MAX_OUTSTANDING];
  logic [PW-1:0]  cnt;
  logic [AW-1:0]  widx, ridx;
  logic [IDW-1:0] gnt, head;
  logic           full, empty, routable, push, pop;
`ifdef JEDRO_1_ARB_ROUND_ROBIN_EN
  logic [IDW-1:0] rr_q, rr_d;
`endif

  assign cnt      = wptr_q - rptr_q;
  assign full     = (cnt == PW'(MAX_OUTSTANDING));
  assign empty    = (cnt == '0);
  assign widx     = AW'(wptr_q & PW'(MAX_OUTSTANDING - 1));
  assign ridx     = AW'(rptr_q & PW'(MAX_OUTSTANDING - 1));
  assign head     = fifo_q[ridx];
  assign routable = active_q && !empty;
  assign outstanding_o = OW'(cnt);

  // A locked grant overrides arbitration so mem_req_* stays stable.
  always_comb begin
    gnt = '0;
    if (lock_q) begin
      gnt = lock_id_q;
    end else begin
`ifdef JEDRO_1_ARB_ROUND_ROBIN_EN
      for (int i = NCH - 1; i >= 0; i--) begin
        if (ch_req_valid_i[(int'(rr_q) + i) % NCH])
          gnt = IDW'((int'(rr_q) + i) % NCH);
      end
`else
      for (int i = NCH - 1; i >= 0; i--) begin
        if (ch_req_valid_i[i]) gnt = IDW'(i);
      end
`endif
    end
  end

  assign mem_req_valid_o  = active_q && !full &&
                            (lock_q || (|ch_req_valid_i));
  assign mem_req_addr_o   = ch_req_addr_i[gnt*XLEN +: XLEN];
  assign mem_req_data_o   = ch_req_data_i[gnt*XLEN +: XLEN];
  assign mem_req_strobe_o = ch_req_strobe_i[gnt*NBYTES +: NBYTES];
  assign mem_req_write_o  = ch_req_write_i[gnt];
  assign push             = mem_req_valid_o && mem_req_ready_i;
  assign ch_rsp_data_o    = {NCH{mem_rsp_data_i}};

  always_comb begin
    ch_req_ready_o      = '0;
    ch_req_ready_o[gnt] = push;
  end

  always_comb begin
    ch_rsp_valid_o  = '0;
    ch_rsp_error_o  = '0;
    mem_rsp_ready_o = 1'b0;
    if (routable) begin
      ch_rsp_valid_o[head] = mem_rsp_valid_i;
      ch_rsp_error_o[head] = mem_rsp_error_i;
      mem_rsp_ready_o      = ch_rsp_ready_i[head];
    end
  end

  assign pop = routable && mem_rsp_valid_i && ch_rsp_ready_i[head];

  always_comb begin
    active_d  = 1'b1;
    lock_d    = mem_req_valid_o && !mem_req_ready_i;
    lock_id_d = gnt;
    wptr_d    = push ? wptr_q + 1'b1 : wptr_q;
    rptr_d    = pop ? rptr_q + 1'b1 : rptr_q;
    fifo_d    = fifo_q;
    if (push) fifo_d[widx] = gnt;
  end

`ifdef JEDRO_1_ARB_ROUND_ROBIN_EN
  always_comb begin
    rr_d = rr_q;
    if (push) rr_d = (int'(gnt) == NCH - 1) ? '0 : gnt + 1'b1;
  end
`endif

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      active_q  <= 1'b0;
      lock_q    <= 1'b0;
      lock_id_q <= '0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      fifo_q    <= '{default: '0};
`ifdef JEDRO_1_ARB_ROUND_ROBIN_EN
      rr_q      <= '0;
`endif
    end else begin
      active_q  <= active_d;
      lock_q    <= lock_d;
      lock_id_q <= lock_id_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      fifo_q    <= fifo_d;
`ifdef JEDRO_1_ARB_ROUND_ROBIN_EN
      rr_q      <= rr_d;
`endif
    end
  end

endmodule
